// File: rtl/iir_pkg.sv
// Shared state encoding, default constants and the saturating-counter helper
// for the IIR sample scheduler.
package iir_pkg;

  typedef enum logic [1:0] {
    StRun,
    StFlush,
    StSettle
  } state_e;

  localparam int unsigned DataWDef     = 16;
  localparam int unsigned FifoDepthDef = 8;
  localparam int unsigned DivDef       = 5;
  localparam int unsigned FlushCycDef  = 4;
  localparam int unsigned EvtCntW      = 16;

  function automatic logic [EvtCntW-1:0] sat_inc(input logic [EvtCntW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Registered single-clock FIFO; a pushed word is visible at the head from the
// cycle after the push. A synchronous clear discards all contents.
module sync_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic              o_full,
  output logic              o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  logic              w_push;
  logic              w_pop;

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

  assign o_head  = r_mem[r_rptr[AW-1:0]];
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: rtl/iir_sample_scheduler.sv
// Paces buffered upstream samples into a biquad at one sample per DIV clocks,
// collects the biquad output into a one-entry register and handles flushes.
module iir_sample_scheduler
  import iir_pkg::*;
#(
  parameter int unsigned DATA_W     = DataWDef,
  parameter int unsigned FIFO_DEPTH = FifoDepthDef,
  parameter int unsigned DIV        = DivDef,
  parameter int unsigned FLUSH_CYC  = FlushCycDef
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  output logic [DATA_W-1:0]  flt_tdata,
  output logic               flt_tvalid,
  input  logic               flt_tready,
  input  logic [DATA_W-1:0]  flt_m_tdata,
  input  logic               flt_m_tvalid,
  output logic               flt_m_tready,
  output logic               flt_rst_n,
  output logic [DATA_W-1:0]  m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  input  logic               flush_req,
  output logic               busy,
  output logic [EvtCntW-1:0] underrun_cnt,
  output logic [EvtCntW-1:0] drop_cnt
);

  localparam int unsigned SlotW  = $clog2(DIV);
  localparam int unsigned FlushW = $clog2(FLUSH_CYC + 1);
  localparam logic [SlotW-1:0]  SlotLast  = SlotW'(DIV - 1);
  localparam logic [FlushW-1:0] FlushLast = FlushW'(FLUSH_CYC - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [FlushW-1:0]  r_flush_cnt;
  logic [SlotW-1:0]   r_slot_cnt;
  logic               w_run;
  logic               w_flush_start;
  logic               w_slot;
  logic               w_issue;
  logic               w_underrun;
  logic               w_push;
  logic               w_capture;
  logic               w_m_hshk;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [DATA_W-1:0]  w_fifo_head;
  logic               r_flt_tvalid;
  logic [DATA_W-1:0]  r_flt_tdata;
  logic               r_m_tvalid;
  logic [DATA_W-1:0]  r_m_tdata;
  logic [EvtCntW-1:0] r_underrun_cnt;
  logic [EvtCntW-1:0] r_drop_cnt;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StRun;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= (r_state == StFlush) ? r_flush_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_run         = 1'b0;
    w_flush_start = 1'b0;
    unique case (r_state)
      StRun: begin
        w_run = 1'b1;
        if (flush_req) begin
          w_flush_start = 1'b1;
          w_state_nxt   = StFlush;
        end
      end
      StFlush: begin
        if (r_flush_cnt == FlushLast) w_state_nxt = StSettle;
      end
      StSettle: w_state_nxt = StRun;
      default:  w_state_nxt = StRun;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sample slot timing and issue
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || !w_run || w_flush_start) begin
      r_slot_cnt <= '0;
    end else if (r_slot_cnt == SlotLast) begin
      r_slot_cnt <= '0;
    end else begin
      r_slot_cnt <= r_slot_cnt + 1'b1;
    end
  end

  // A slot coinciding with a flush request is consumed by the flush.
  assign w_slot     = w_run && !flush_req && (r_slot_cnt == SlotLast);
  assign w_issue    = w_slot && !w_fifo_empty && flt_tready;
  assign w_underrun = w_slot && !w_issue;

  assign s_axis_tready = !rst && w_run && !w_fifo_full;
  assign w_push        = s_axis_tvalid && s_axis_tready;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clr   (w_flush_start),
    .i_push  (w_push),
    .i_data  (s_axis_tdata),
    .i_pop   (w_issue),
    .o_head  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flt_tvalid <= 1'b0;
      r_flt_tdata  <= '0;
    end else begin
      r_flt_tvalid <= w_issue;
      if (w_issue) r_flt_tdata <= w_fifo_head;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_underrun_cnt <= '0;
    end else if (w_underrun) begin
      r_underrun_cnt <= sat_inc(r_underrun_cnt);
    end
  end

  // ---------------------------------------------------------------------------
  // Output holding register
  // ---------------------------------------------------------------------------
  assign w_capture = flt_m_tvalid && w_run;
  assign w_m_hshk  = r_m_tvalid && m_axis_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_drop_cnt <= '0;
    end else if (w_flush_start) begin
      r_m_tvalid <= 1'b0;
    end else if (w_capture) begin
      r_m_tvalid <= 1'b1;
      r_m_tdata  <= flt_m_tdata;
      // Overwriting a word that is not leaving this cycle loses it.
      if (r_m_tvalid && !m_axis_tready) r_drop_cnt <= sat_inc(r_drop_cnt);
    end else if (w_m_hshk) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign flt_tvalid    = r_flt_tvalid;
  assign flt_tdata     = r_flt_tdata;
  assign flt_m_tready  = 1'b1;
  assign flt_rst_n     = !rst && (r_state != StFlush);
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tdata  = r_m_tdata;
  assign busy          = (r_state != StRun);
  assign underrun_cnt  = r_underrun_cnt;
  assign drop_cnt      = r_drop_cnt;

endmodule

// File: doc/iir_sample_scheduler.md
IIR_SAMPLE_SCHEDULER -- requirements
Module: iir_sample_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width (signed, two's complement).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, input buffer depth, power of two, at least 2.
REQ-003 SHALL have parameter DIV, default 5, clocks per sample slot (50 MHz clk to 10 MHz fs), at least 2.
REQ-004 SHALL have parameter FLUSH_CYC, default 4, cycles the filter reset is held during a flush.
REQ-005 SHALL have ports: clk, in, 1, sole clock, all logic on its rising edge.
REQ-006 SHALL have ports: rst, in, 1, synchronous active-high reset.
REQ-007 SHALL have ports: s_axis_tdata/tvalid/tready, in/in/out, DATA_W/1/1, upstream sample stream.
REQ-008 SHALL have ports: flt_tdata/flt_tvalid, out, DATA_W/1, drive the biquad slave input.
REQ-009 SHALL have ports: flt_tready, in, 1, biquad slave ready.
REQ-010 SHALL have ports: flt_m_tdata/flt_m_tvalid, in, DATA_W/1, biquad master output.
REQ-011 SHALL have ports: flt_m_tready, out, 1, tied high (biquad never stalled).
REQ-012 SHALL have ports: flt_rst_n, out, 1, active-low reset to the biquad.
REQ-013 SHALL have ports: m_axis_tdata/tvalid/tready, out/out/in, DATA_W/1/1, downstream filtered stream.
REQ-014 SHALL have ports: flush_req, in, 1, single-cycle request to clear filter state and buffers.
REQ-015 SHALL have ports: busy, out, 1, high while not in RUN.
REQ-016 SHALL have ports: underrun_cnt/drop_cnt, out, 16/16, saturating event counters.

Function
REQ-017 SHALL implement FSM states RUN, FLUSH, SETTLE: RUN to FLUSH on flush_req; FLUSH to SETTLE after FLUSH_CYC cycles; SETTLE to RUN after 1 cycle; flush_req outside RUN is ignored.
REQ-018 SHALL assert s_axis_tready = (state==RUN) && FIFO not full; a push occurs on tvalid && tready.
REQ-019 SHALL run a slot counter 0..DIV-1 in RUN, wrapping; a slot occurs when counter==DIV-1; the counter is held at 0 outside RUN.
REQ-020 SHALL, at a slot with FIFO non-empty and flt_tready high, drive flt_tvalid high for exactly one cycle with flt_tdata = FIFO head, then pop.
REQ-021 SHALL treat a slot with FIFO empty or flt_tready low as an underrun: no issue, underrun_cnt+1, saturating at 0xFFFF.
REQ-022 SHALL make a sample pushed at edge k eligible for issue no earlier than the slot at edge k+1 (registered FIFO).
REQ-023 SHALL permit simultaneous push and pop; occupancy is unchanged and ordering is strictly FIFO.
REQ-024 SHALL capture flt_m_tdata into a 1-entry output register on flt_m_tvalid, setting m_axis_tvalid the next cycle.
REQ-025 SHALL hold m_axis_tvalid/tdata stable until m_axis_tready; the register clears on handshake unless a new capture coincides.
REQ-026 SHALL, on capture while the register holds unaccepted data, overwrite it with the new sample and increment drop_cnt (saturating).
REQ-027 SHALL, on capture coinciding with a downstream handshake, count no drop and present the new sample.
REQ-028 SHALL, on entering FLUSH, empty the FIFO, clear m_axis_tvalid, hold flt_rst_n low for FLUSH_CYC cycles, and keep flt_tvalid low; counters are retained.
REQ-029 SHALL ignore flt_m_tvalid during FLUSH and SETTLE.

Reset
REQ-030 SHALL, with rst high, force state=RUN, slot counter=0, FIFO empty, flt_tvalid=0, m_axis_tvalid=0, m_axis_tdata=0, flt_tdata=0, flt_rst_n=0, underrun_cnt=0, drop_cnt=0, busy=0, s_axis_tready=0.
REQ-031 SHALL drive flt_rst_n=1 from the first cycle after rst deasserts; mid-operation rst discards all buffered samples with no outputs produced.

Structure
REQ-032 SHALL place the FSM state enum and default DATA_W/DIV/FLUSH_CYC constants in shared package iir_pkg.
REQ-033 SHALL implement the buffer as sub-module sync_fifo (parameters DATA_W and DEPTH; ports for push, pop, full, empty, head).

Verification
REQ-034 SHALL have a directed test where an impulse 32767 followed by 50 zeros, upstream always valid, issues one flt_tvalid every 5 clocks and yields an output sequence matching the golden biquad model (b=2962,5615,2962; a1=-9362; a2=5203; scale 2^14).
REQ-035 SHALL have a directed test where 9 back-to-back pushes with DIV=5 drop s_axis_tready after 8 accepted samples and reassert it after the first issue, with no data loss.
REQ-036 SHALL have a directed test where upstream idles for 3 slots and underrun_cnt=3 results, with no flt_tvalid during them.
REQ-037 SHALL have a directed test where m_axis_tready is held low across 3 filter outputs, leaving drop_cnt=2 and m_axis_tdata equal to the third output when ready returns.
REQ-038 SHALL have a directed test where flush_req with 5 samples buffered gives busy=1 for 5 cycles and flt_rst_n low for 4 cycles, an empty FIFO, and m_axis_tvalid=0.
REQ-039 SHALL have a directed test where rst is asserted mid-stream and all outputs match REQ-030 on the next edge.
